// File: rtl/pio_mem_rd_arb_if.sv
// Bus bundle for pio_mem_rd_arb: PIO register path, app read requesters and RAM ports.
// slave is the arbiter's view; master is the view of everything around it.
interface pio_mem_rd_arb_if #(
    parameter int WIDTH       = 20,
    parameter int DEPTH_NBITS = 10,
    parameter int NREQ        = 4
);
    logic [31:0]               reg_addr;
    logic [31:0]               reg_din;
    logic                      reg_rd;
    logic                      reg_wr;
    logic                      reg_ms;
    logic                      mem_ack;
    logic [31:0]               mem_rdata;

    logic [NREQ-1:0]             app_req;
    logic [NREQ*DEPTH_NBITS-1:0] app_raddr;
    logic [NREQ-1:0]             app_gnt;
    logic [NREQ-1:0]             app_ack;
    logic [WIDTH-1:0]            app_rdata;

    logic [DEPTH_NBITS-1:0]    ram_raddr;
    logic                      ram_wr;
    logic [DEPTH_NBITS-1:0]    ram_waddr;
    logic [WIDTH-1:0]          ram_wdata;
    logic [WIDTH-1:0]          ram_rdata;

    modport slave (
        input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        input  app_req, app_raddr, ram_rdata,
        output mem_ack, mem_rdata, app_gnt, app_ack, app_rdata,
        output ram_raddr, ram_wr, ram_waddr, ram_wdata
    );

    modport master (
        output reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        output app_req, app_raddr, ram_rdata,
        input  mem_ack, mem_rdata, app_gnt, app_ack, app_rdata,
        input  ram_raddr, ram_wr, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/pio_mem_rd_arb.sv
// Shares the read port of a 1R1W table RAM between NREQ app requesters and PIO reads,
// owns the PIO write port and returns PIO completions on a clk_div-paced mem_ack.
module pio_mem_rd_arb #(
    parameter int WIDTH        = 20,
    parameter int DEPTH_NBITS  = 10,
    parameter int NREQ         = 4,
    parameter int PIO_MAX_WAIT = 8
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clk_div,
    pio_mem_rd_arb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (PIO_MAX_WAIT > 0) ? $clog2(PIO_MAX_WAIT + 1) : 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, ACK_SET, ACK_HOLD} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          rr_ptr, rr_ptr_nxt, sel, idx;
    logic [WW-1:0]          pio_wait;
    logic [DEPTH_NBITS-1:0] pio_idx, reg_idx, raddr, raddr_q;
    logic [NREQ-1:0]        gnt;
    logic                   app_any, pio_pend, pio_force, pio_gnt, app_win;
    logic                   unused_ok;

    assign reg_idx   = bus.reg_addr[DEPTH_NBITS+1:2];
    assign unused_ok = ^{bus.reg_addr, bus.reg_din};
    assign app_any   = |bus.app_req;
    assign pio_pend  = (state == RD_WAIT);
    assign pio_force = pio_pend && (pio_wait == WW'(PIO_MAX_WAIT));

    // Grant is gated by reset so nothing is granted while rst_n is low.
    always_comb begin
        gnt        = '0;
        raddr      = raddr_q;
        rr_ptr_nxt = rr_ptr;
        pio_gnt    = 1'b0;
        app_win    = 1'b0;
        sel        = '0;
        idx        = '0;
        if (rst_n) begin
            if (pio_pend && (!app_any || pio_force)) begin
                pio_gnt = 1'b1;
                raddr   = pio_idx;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    idx = PW'((32'(rr_ptr) + k) % NREQ);
                    if (!app_win && bus.app_req[idx]) begin
                        app_win = 1'b1;
                        sel     = idx;
                    end
                end
                if (app_win) begin
                    gnt        = NREQ'(1) << sel;
                    raddr      = bus.app_raddr[sel*DEPTH_NBITS +: DEPTH_NBITS];
                    rr_ptr_nxt = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end

    assign bus.app_gnt   = gnt;
    assign bus.ram_raddr = raddr;
    assign bus.app_rdata = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            raddr_q     <= '0;
            pio_wait    <= '0;
            bus.app_ack <= '0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            raddr_q     <= raddr;
            bus.app_ack <= gnt;
            if (pio_gnt)
                pio_wait <= '0;
            else if (pio_pend)
                pio_wait <= pio_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.reg_ms && bus.reg_wr)      state_nxt = ACK_SET;
                else if (bus.reg_ms && bus.reg_rd) state_nxt = RD_WAIT;
            end
            RD_WAIT:  if (pio_gnt) state_nxt = RD_DATA;
            RD_DATA:  state_nxt = ACK_SET;
            ACK_SET:  if (clk_div) state_nxt = ACK_HOLD;
            ACK_HOLD: if (clk_div) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
            bus.ram_wr    <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_wdata <= '0;
            pio_idx       <= '0;
        end else begin
            bus.ram_wr <= 1'b0;
            if (state == IDLE && bus.reg_ms) begin
                if (bus.reg_wr) begin
                    bus.ram_wr    <= 1'b1;
                    bus.ram_waddr <= reg_idx;
                    bus.ram_wdata <= bus.reg_din[WIDTH-1:0];
                end else if (bus.reg_rd) begin
                    pio_idx <= reg_idx;
                end
            end
            if (state == RD_DATA)
                bus.mem_rdata <= 32'(bus.ram_rdata);
            if (state == ACK_SET && clk_div)
                bus.mem_ack <= 1'b1;
            if (state == ACK_HOLD && clk_div)
                bus.mem_ack <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Directed bench for pio_mem_rd_arb: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares them whenever the DUT presents an ack or write.
module tb_pio_mem_rd_arb;
    logic clk, rst_n, clk_div;
    int   divc;

    typedef struct packed { logic [3:0] ack; logic [19:0] data; } app_t;
    typedef struct packed { logic rd; logic [19:0] data; } pio_t;
    typedef struct packed { logic [9:0] addr; logic [19:0] data; } wr_t;

    app_t app_q[$];
    pio_t pio_q[$];
    wr_t  wr_q[$];

    logic [3:0]  gnt_exp;
    logic [9:0]  raddr_exp;
    logic        gnt_chk, raddr_chk, rst_chk, done, fin;
    int          vectors, miscompares;
    logic [19:0] ram [1024];

    pio_mem_rd_arb_if #(.WIDTH(20), .DEPTH_NBITS(10), .NREQ(4)) bus ();

    pio_mem_rd_arb #(.WIDTH(20), .DEPTH_NBITS(10), .NREQ(4), .PIO_MAX_WAIT(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .bus     (bus)
    );

    function automatic logic [19:0] pat(input int unsigned i);
        return 20'h30000 + 20'(i * 7);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = pat(i);
        ram[5] = 20'h00001;
    end

    always @(posedge clk) begin
        if (bus.ram_wr) ram[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_raddr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_div = 1'b0;
        divc    = 0;
        forever begin
            @(posedge clk);
            #1;
            clk_div = (divc == 3);
            divc    = (divc + 1) % 4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, want finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: the only process that makes comparisons.
    initial begin
        logic prev_ack, prev_wr;
        int   ack_w;
        app_t a;
        pio_t p;
        wr_t  w;
        prev_ack = 1'b0; prev_wr = 1'b0; ack_w = 0;
        vectors = 0; miscompares = 0; fin = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_chk) begin
                vectors++;
                if ({bus.mem_ack, bus.mem_rdata, bus.app_gnt, bus.app_ack, bus.ram_wr,
                     bus.ram_waddr, bus.ram_wdata, bus.ram_raddr} != '0) begin
                    miscompares++;
                    $display("FAIL reset_zero: got ack=%0b rdata=%h gnt=%h aack=%h wr=%0b waddr=%h wdata=%h raddr=%h, want all 0",
                             bus.mem_ack, bus.mem_rdata, bus.app_gnt, bus.app_ack, bus.ram_wr,
                             bus.ram_waddr, bus.ram_wdata, bus.ram_raddr);
                end
                prev_ack = 1'b0; prev_wr = 1'b0; ack_w = 0;
            end else begin
                if (gnt_chk) begin
                    vectors++;
                    if (bus.app_gnt !== gnt_exp) begin
                        miscompares++;
                        $display("FAIL app_gnt @%0t: got %h want %h", $time, bus.app_gnt, gnt_exp);
                    end
                end
                if (raddr_chk) begin
                    vectors++;
                    if (bus.ram_raddr !== raddr_exp) begin
                        miscompares++;
                        $display("FAIL ram_raddr @%0t: got %0d want %0d", $time, bus.ram_raddr, raddr_exp);
                    end
                end
                if (bus.app_ack != '0) begin
                    vectors++;
                    if (app_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL app_ack_unexpected @%0t: got %h want none", $time, bus.app_ack);
                    end else begin
                        a = app_q.pop_front();
                        if (bus.app_ack !== a.ack || bus.app_rdata !== a.data) begin
                            miscompares++;
                            $display("FAIL app_ack @%0t: got ack=%h data=%h want ack=%h data=%h",
                                     $time, bus.app_ack, bus.app_rdata, a.ack, a.data);
                        end
                    end
                end
                if (bus.ram_wr) begin
                    vectors++;
                    if (prev_wr) begin
                        miscompares++;
                        $display("FAIL ram_wr_pulse @%0t: got 2-cycle pulse want 1", $time);
                    end else if (wr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL ram_wr_unexpected @%0t: got addr=%0d want none", $time, bus.ram_waddr);
                    end else begin
                        w = wr_q.pop_front();
                        if (bus.ram_waddr !== w.addr || bus.ram_wdata !== w.data) begin
                            miscompares++;
                            $display("FAIL ram_wr @%0t: got addr=%0d data=%h want addr=%0d data=%h",
                                     $time, bus.ram_waddr, bus.ram_wdata, w.addr, w.data);
                        end
                    end
                end
                if (bus.mem_ack && !prev_ack) begin
                    vectors++;
                    ack_w = 0;
                    if (pio_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL mem_ack_unexpected @%0t: got rise want none", $time);
                    end else begin
                        p = pio_q.pop_front();
                        if (p.rd && bus.mem_rdata !== {12'h000, p.data}) begin
                            miscompares++;
                            $display("FAIL mem_rdata @%0t: got %h want %h", $time, bus.mem_rdata, {12'h000, p.data});
                        end
                    end
                end
                if (!bus.mem_ack && prev_ack) begin
                    vectors++;
                    if (ack_w != 4) begin
                        miscompares++;
                        $display("FAIL mem_ack_width @%0t: got %0d clks want 4", $time, ack_w);
                    end
                end
                if (bus.mem_ack) ack_w++;
                prev_ack = bus.mem_ack;
                prev_wr  = bus.ram_wr;
            end
            if (done && !fin) begin
                vectors += 3;
                if (app_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL app_leftover: got %0d pending want 0", app_q.size());
                end
                if (pio_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL pio_leftover: got %0d pending want 0", pio_q.size());
                end
                if (wr_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL wr_leftover: got %0d pending want 0", wr_q.size());
                end
                fin = 1'b1;
            end
        end
    end

    task automatic setpio(input logic ms, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] din);
        bus.reg_ms = ms; bus.reg_rd = rd; bus.reg_wr = wr;
        bus.reg_addr = addr; bus.reg_din = din;
    endtask

    // Arm this cycle's grant/raddr expectation, queue the ack it implies, advance a clock.
    task automatic step(input logic [3:0] eg, input logic [19:0] d, input int ra);
        gnt_chk   = 1'b1;
        gnt_exp   = eg;
        raddr_chk = (ra >= 0);
        raddr_exp = 10'(ra);
        if (eg != 4'h0) app_q.push_back({eg, d});
        @(posedge clk);
        #1;
    endtask

    // Grant to requester i with the default address table {7,3,2,1}.
    task automatic gstep(input int i);
        int unsigned addr [4];
        addr = '{1, 2, 3, 7};
        step(4'(1 << i), pat(addr[i]), int'(addr[i]));
    endtask

    initial begin
        rst_n = 1'b0; rst_chk = 1'b0; gnt_chk = 1'b0; raddr_chk = 1'b0; done = 1'b0;
        gnt_exp = '0; raddr_exp = '0;
        bus.app_req   = 4'hF;
        bus.app_raddr = {10'd7, 10'd3, 10'd2, 10'd1};
        setpio(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;

        // Reset with requests and a PIO read pending
        rst_chk = 1'b1;
        repeat (3) step(4'h0, '0, -1);

        // Round-robin over all four requesters
        rst_chk = 1'b0; rst_n = 1'b1;
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) gstep(k % 4);

        // PIO starvation: forced on the 9th RD_WAIT cycle
        bus.app_req = 4'h3;
        setpio(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        pio_q.push_back({1'b1, pat(4)});
        gstep(0);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 8; k++) gstep((k % 2 == 1) ? 1 : 0);
        step(4'h0, '0, 4);
        gstep(1);
        gstep(0);
        bus.app_req = 4'h0;
        repeat (16) step(4'h0, '0, -1);

        // PIO write (with reg_rd also set), then app read and aliased PIO read
        setpio(1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFA_BCDE);
        wr_q.push_back({10'd16, 20'hABCDE});
        pio_q.push_back({1'b0, 20'h0});
        step(4'h0, '0, -1);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (14) step(4'h0, '0, -1);
        bus.app_raddr[9:0] = 10'd16;
        bus.app_req = 4'h1;
        step(4'h1, 20'hABCDE, 16);
        bus.app_req = 4'h0;
        step(4'h0, '0, 16);
        setpio(1'b1, 1'b1, 1'b0, 32'h8000_1040, 32'h0);
        pio_q.push_back({1'b1, 20'hABCDE});
        step(4'h0, '0, 16);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(4'h0, '0, 16);
        repeat (15) step(4'h0, '0, -1);

        // Same-cycle write and read of index 5: old data, then new
        setpio(1'b1, 1'b0, 1'b1, 32'h14, 32'h0007_F00F);
        wr_q.push_back({10'd5, 20'h7F00F});
        pio_q.push_back({1'b0, 20'h0});
        step(4'h0, '0, -1);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.app_raddr[9:0] = 10'd5;
        bus.app_req = 4'h1;
        step(4'h1, 20'h00001, 5);
        step(4'h1, 20'h7F00F, 5);
        bus.app_req = 4'h0;
        step(4'h0, '0, 5);
        repeat (12) step(4'h0, '0, -1);

        // Reset while the PIO read waits in RD_WAIT
        bus.app_raddr = {10'd7, 10'd3, 10'd2, 10'd1};
        bus.app_req = 4'hF;
        setpio(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        gstep(1);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        gstep(2);
        gstep(3);
        rst_n = 1'b0;
        step(4'h0, '0, -1);
        rst_chk = 1'b1;
        repeat (2) step(4'h0, '0, -1);
        rst_chk = 1'b0; rst_n = 1'b1;
        bus.app_req = 4'h0;
        repeat (20) step(4'h0, '0, -1);

        // Reset while mem_ack is held in ACK_HOLD
        setpio(1'b1, 1'b1, 1'b0, 32'h1C, 32'h0);
        pio_q.push_back({1'b1, pat(7)});
        step(4'h0, '0, -1);
        setpio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 20 && !bus.mem_ack; n++) step(4'h0, '0, -1);
        rst_n = 1'b0;
        step(4'h0, '0, -1);
        rst_chk = 1'b1;
        repeat (2) step(4'h0, '0, -1);
        rst_chk = 1'b0; rst_n = 1'b1;
        repeat (20) step(4'h0, '0, -1);
        bus.app_req = 4'hF;
        gstep(0);
        bus.app_req = 4'h0;
        repeat (3) step(4'h0, '0, -1);

        done = 1'b1;
        wait (fin);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
